vga_timing_ctrl: RTL and testbench

//  Multi-mode VGA timing generator, pixel-clock domain.
//  - Selects its timing from a compile-time mode table; the mode changes at runtime, only at a frame boundary.
//  - Requests pixels by coordinate and tolerates a pixel source of parameterised latency.
//  - Delays hs/vs so they stay aligned with the registered RGB stream.
//  - Sits between the Tetris renderer and the DAC/pins.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_delay_line.sv | 41 ++++
 rtl/vga_timing_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg: timing record, compile-time mode table and frame-size helpers.
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int coord_w_c   = 12;
  localparam int max_modes_c = 4;

  typedef logic [coord_w_c-1:0] coord_t;

  typedef struct packed {
    coord_t width;
    coord_t height;
    coord_t h_pulse;
    coord_t h_bp;
    coord_t h_fp;
    coord_t v_pulse;
    coord_t v_bp;
    coord_t v_fp;
    logic   hs_pol;
    logic   vs_pol;
  } vga_timing_s;

  typedef vga_timing_s [max_modes_c-1:0] mode_table_t;

  // Slots beyond the populated entries are all-zero; only indices below
  // num_modes_p are ever selected by the controller.
  localparam mode_table_t mode_table_c = '{
    0: '{12'd800, 12'd600, 12'd72, 12'd128, 12'd24, 12'd2, 12'd22, 12'd1, 1'b1, 1'b1},
    1: '{12'd640, 12'd480, 12'd96, 12'd48,  12'd16, 12'd2, 12'd33, 12'd10, 1'b0, 1'b0},
    default: '0
  };

  function automatic coord_t h_total_f(vga_timing_s t);
    return t.h_pulse + t.h_bp + t.width + t.h_fp;
  endfunction

  function automatic coord_t v_total_f(vga_timing_s t);
    return t.v_pulse + t.v_bp + t.height + t.v_fp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// vga_delay_line: fixed-depth shift register with synchronous reset value.
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_delay_line #(
  parameter int               width_p     = 1,
  parameter int               depth_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  generate
    if (depth_p == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk_i, reset_i};
      assign q_o = d_i;
    end else begin : g_shift
      logic [width_p-1:0] stage_r [depth_p];

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          for (int i = 0; i < depth_p; i++) stage_r[i] <= reset_val_p;
        end else begin
          stage_r[0] <= d_i;
          for (int i = 1; i < depth_p; i++) stage_r[i] <= stage_r[i-1];
        end
      end

      assign q_o = stage_r[depth_p-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// ============================================================================
// vga_timing_ctrl: multi-mode VGA timing/pixel pipeline; optional colour-bar
// source enabled by VGA_TEST_PATTERN_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int          bit_depth_p    = 8,
  parameter int          x_width_p      = 11,
  parameter int          y_width_p      = 10,
  parameter int          pixel_lat_p    = 1,
  parameter int          num_modes_p    = 2,
  parameter int          default_mode_p = 0,
  parameter mode_table_t mode_table_p   = mode_table_c
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [$clog2(num_modes_p)-1:0] mode_i,
  input  logic                           mode_v_i,
  output logic                           mode_ready_o,
  output logic [$clog2(num_modes_p)-1:0] mode_o,
  input  logic [bit_depth_p-1:0]         r_i,
  input  logic [bit_depth_p-1:0]         g_i,
  input  logic [bit_depth_p-1:0]         b_i,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                           test_pattern_i,
`endif
  output logic [x_width_p-1:0]           x_o,
  output logic [y_width_p-1:0]           y_o,
  output logic                           xy_v_o,
  output logic                           frame_start_o,
  output logic [bit_depth_p-1:0]         r_o,
  output logic [bit_depth_p-1:0]         g_o,
  output logic [bit_depth_p-1:0]         b_o,
  output logic                           hs_o,
  output logic                           vs_o
);

  localparam int          mode_w_lp    = $clog2(num_modes_p);
  localparam vga_timing_s def_mode_lp  = mode_table_p[default_mode_p];
  localparam logic [1:0]  sync_idle_lp = {~def_mode_lp.vs_pol, ~def_mode_lp.hs_pol};

  logic [mode_w_lp-1:0] mode_r, pend_mode_r;
  logic                 pending_r;
  coord_t               h_r, v_r;

  vga_timing_s cfg;
  coord_t      h_total, v_total, h_start, v_start;
  logic        h_last, v_last, frame_end, active, at_origin;
  logic        hs_raw, vs_raw, mode_ok, pix_v;
  logic [1:0]  sync_q;

  assign cfg       = mode_table_p[mode_r];
  assign h_total   = h_total_f(cfg);
  assign v_total   = v_total_f(cfg);
  assign h_start   = cfg.h_pulse + cfg.h_bp;
  assign v_start   = cfg.v_pulse + cfg.v_bp;
  assign h_last    = (h_r == h_total - 12'd1);
  assign v_last    = (v_r == v_total - 12'd1);
  assign frame_end = h_last && v_last;
  assign active    = (h_r >= h_start) && (h_r < h_start + cfg.width) &&
                     (v_r >= v_start) && (v_r < v_start + cfg.height);
  assign at_origin = (h_r == h_start) && (v_r == v_start);
  assign hs_raw    = (h_r < cfg.h_pulse) ? cfg.hs_pol : ~cfg.hs_pol;
  assign vs_raw    = (v_r < cfg.v_pulse) ? cfg.vs_pol : ~cfg.vs_pol;
  assign mode_ok   = int'(mode_i) < num_modes_p;

  assign mode_ready_o = !pending_r;
  assign mode_o       = mode_r;

  // Counters and mode handshake; a new mode only takes effect as the
  // counters wrap, so every frame is generated entirely under one mode.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_r         <= '0;
      v_r         <= '0;
      mode_r      <= mode_w_lp'(default_mode_p);
      pend_mode_r <= '0;
      pending_r   <= 1'b0;
    end else begin
      if (h_last) begin
        h_r <= '0;
        v_r <= v_last ? '0 : v_r + 12'd1;
      end else begin
        h_r <= h_r + 12'd1;
      end
      if (frame_end && pending_r) begin
        mode_r    <= pend_mode_r;
        pending_r <= 1'b0;
      end
      // Out-of-range indices are acknowledged but never queued.
      if (mode_v_i && mode_ready_o && mode_ok) begin
        pending_r   <= 1'b1;
        pend_mode_r <= mode_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_o           <= '0;
      y_o           <= '0;
      xy_v_o        <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      x_o           <= x_width_p'(h_r - h_start);
      y_o           <= y_width_p'(v_r - v_start);
      xy_v_o        <= active;
      frame_start_o <= at_origin;
    end
  end

  vga_delay_line #(
    .width_p     (1),
    .depth_p     (pixel_lat_p),
    .reset_val_p (1'b0)
  ) u_valid_dly (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (xy_v_o),
    .q_o     (pix_v)
  );

  // Counter stage + request stage + pixel_lat_p + output register.
  vga_delay_line #(
    .width_p     (2),
    .depth_p     (pixel_lat_p + 2),
    .reset_val_p (sync_idle_lp)
  ) u_sync_dly (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     ({vs_raw, hs_raw}),
    .q_o     (sync_q)
  );

  assign {vs_o, hs_o} = sync_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [x_width_p-1:0] pix_x;
  logic [31:0]          bar_num, bar_den;
  logic [2:0]           bar;

  vga_delay_line #(
    .width_p     (x_width_p),
    .depth_p     (pixel_lat_p),
    .reset_val_p ('0)
  ) u_x_dly (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (x_o),
    .q_o     (pix_x)
  );

  assign bar_num = 32'(pix_x) << 3;
  assign bar_den = 32'(cfg.width);
  assign bar     = 3'(bar_num / bar_den);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i || !pix_v) begin
      r_o <= '0;
      g_o <= '0;
      b_o <= '0;
    end else begin
`ifdef VGA_TEST_PATTERN_EN
      if (test_pattern_i) begin
        r_o <= {bit_depth_p{bar[2]}};
        g_o <= {bit_depth_p{bar[1]}};
        b_o <= {bit_depth_p{bar[0]}};
      end else begin
        r_o <= r_i;
        g_o <= g_i;
        b_o <= b_i;
      end
`else
      r_o <= r_i;
      g_o <= g_i;
      b_o <= b_i;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// ============================================================================
// tb_vga_timing_ctrl: scoreboard bench for vga_timing_ctrl on a reduced table.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_ctrl;
  import vga_pkg::*;

  localparam int LAT = 1;
  localparam int NM  = 3;

  // Small modes keep frames short: 15x8, 12x8 and 7x5 clocks.
  localparam mode_table_t TB_TABLE = '{
    0: '{12'd8, 12'd4, 12'd2, 12'd3, 12'd2, 12'd1, 12'd2, 12'd1, 1'b1, 1'b1},
    1: '{12'd6, 12'd3, 12'd3, 12'd2, 12'd1, 12'd2, 12'd1, 12'd2, 1'b0, 1'b0},
    2: '{12'd4, 12'd2, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 1'b0, 1'b1},
    default: '0
  };

  typedef struct packed {
    logic        v;
    logic        fs;
    logic        chk;
    logic [10:0] x;
    logic [9:0]  y;
  } req_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [1:0] mode_i = 2'd0;
  logic       mode_v_i = 1'b0;
  logic       mode_ready_o;
  logic [1:0] mode_o;
  logic [7:0] r_i = 8'd0, g_i = 8'd0, b_i = 8'hA5;
  logic [10:0] x_o;
  logic [9:0]  y_o;
  logic        xy_v_o, frame_start_o, hs_o, vs_o;
  logic [7:0]  r_o, g_o, b_o;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_pattern_i = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .bit_depth_p    (8),
    .x_width_p      (11),
    .y_width_p      (10),
    .pixel_lat_p    (LAT),
    .num_modes_p    (NM),
    .default_mode_p (0),
    .mode_table_p   (TB_TABLE)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .mode_i         (mode_i),
    .mode_v_i       (mode_v_i),
    .mode_ready_o   (mode_ready_o),
    .mode_o         (mode_o),
    .r_i            (r_i),
    .g_i            (g_i),
    .b_i            (b_i),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern_i (test_pattern_i),
`endif
    .x_o            (x_o),
    .y_o            (y_o),
    .xy_v_o         (xy_v_o),
    .frame_start_o  (frame_start_o),
    .r_o            (r_o),
    .g_o            (g_o),
    .b_o            (b_o),
    .hs_o           (hs_o),
    .vs_o           (vs_o)
  );

  int total = 0, bad = 0, cyc = 0;
  int n_act, n_hs, n_vs, n_fs = 0, fs_last = 0, fs_period = 0;
  int bm_h, bm_v, bm_mode, bm_pmode;
  bit bm_pend, tp = 1'b0;
  req_t req_q[$];
  pix_t pix_q[$];
  logic [10:0] srcx_q[$];
  logic [9:0]  srcy_q[$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: advance the reference model, compare against the queued
  // expectations, queue the new ones and drive the pixel source.
  task automatic tick();
    vga_timing_s t;
    int ht, vt, hs0, vs0;
    bit acc, fe, act;
    req_t er, gr;
    pix_t ep, gp;
    logic [10:0] sx;
    logic [9:0]  sy;
    logic [2:0]  bar;
    @(posedge clk);
    #1;
    cyc++;
    if (reset_i) begin
      bm_h = 0; bm_v = 0; bm_mode = 0; bm_pend = 1'b0;
      req_q.delete();
      pix_q.delete();
      req_q.push_back('{v: 1'b0, fs: 1'b0, chk: 1'b1, x: 11'd0, y: 10'd0});
      t = TB_TABLE[0];
      repeat (LAT + 2)
        pix_q.push_back('{hs: ~t.hs_pol, vs: ~t.vs_pol, r: 8'd0, g: 8'd0, b: 8'd0});
    end else begin
      t  = TB_TABLE[bm_mode];
      ht = int'(h_total_f(t));
      vt = int'(v_total_f(t));
      fe  = (bm_h == ht - 1) && (bm_v == vt - 1);
      acc = mode_v_i && !bm_pend;
      if (bm_h == ht - 1) begin
        bm_h = 0;
        bm_v = (bm_v == vt - 1) ? 0 : bm_v + 1;
      end else begin
        bm_h++;
      end
      if (fe && bm_pend) begin
        bm_mode = bm_pmode;
        bm_pend = 1'b0;
      end
      if (acc && int'(mode_i) < NM) begin
        bm_pend  = 1'b1;
        bm_pmode = int'(mode_i);
      end
    end

    t   = TB_TABLE[bm_mode];
    hs0 = int'(t.h_pulse) + int'(t.h_bp);
    vs0 = int'(t.v_pulse) + int'(t.v_bp);
    act = bm_h >= hs0 && bm_h < hs0 + int'(t.width) &&
          bm_v >= vs0 && bm_v < vs0 + int'(t.height);
    er = '{v: act, fs: act && bm_h == hs0 && bm_v == vs0, chk: act,
           x: 11'(bm_h - hs0), y: 10'(bm_v - vs0)};
    ep.hs = (bm_h < int'(t.h_pulse)) ? t.hs_pol : ~t.hs_pol;
    ep.vs = (bm_v < int'(t.v_pulse)) ? t.vs_pol : ~t.vs_pol;
    ep.r = 8'd0; ep.g = 8'd0; ep.b = 8'd0;
    if (act) begin
      if (tp) begin
        bar  = 3'(((bm_h - hs0) * 8) / int'(t.width));
        ep.r = {8{bar[2]}};
        ep.g = {8{bar[1]}};
        ep.b = {8{bar[0]}};
      end else begin
        ep.r = 8'(bm_h - hs0);
        ep.g = 8'(bm_v - vs0);
        ep.b = 8'hA5;
      end
    end

    gr = req_q.pop_front();
    total++;
    assert ({xy_v_o, frame_start_o} === {gr.v, gr.fs}) else begin
      bad++;
      $error("FAIL req_flags cyc=%0d got=%b exp=%b", cyc, {xy_v_o, frame_start_o}, {gr.v, gr.fs});
    end
    if (gr.chk) begin
      total++;
      assert ({x_o, y_o} === {gr.x, gr.y}) else begin
        bad++;
        $error("FAIL req_xy cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc, x_o, y_o, gr.x, gr.y);
      end
    end
    gp = pix_q.pop_front();
    total++;
    assert ({hs_o, vs_o, r_o, g_o, b_o} === gp) else begin
      bad++;
      $error("FAIL pixel cyc=%0d got=%h exp=%h", cyc, {hs_o, vs_o, r_o, g_o, b_o}, gp);
    end
    total++;
    assert (mode_o === 2'(bm_mode) && mode_ready_o === !bm_pend) else begin
      bad++;
      $error("FAIL mode cyc=%0d got=%0d/%b exp=%0d/%b", cyc, mode_o, mode_ready_o, bm_mode, !bm_pend);
    end
    req_q.push_back(er);
    pix_q.push_back(ep);

    if (xy_v_o) n_act++;
    if (hs_o) n_hs++;
    if (vs_o) n_vs++;
    if (frame_start_o) begin
      n_fs++;
      fs_period = cyc - fs_last;
      fs_last   = cyc;
    end

    srcx_q.push_back(x_o);
    srcy_q.push_back(y_o);
    sx  = srcx_q.pop_front();
    sy  = srcy_q.pop_front();
    r_i = sx[7:0];
    g_i = sy[7:0];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    n_act = 0; n_hs = 0; n_vs = 0;
  endtask

  task automatic wait_fs();
    int n = 0;
    int s = n_fs;
    while (n_fs == s && n < 1000) begin
      tick();
      n++;
    end
    check("frame_start_seen", n_fs - s, 1);
  endtask

  task automatic request(input logic [1:0] m);
    mode_i   = m;
    mode_v_i = 1'b1;
    tick();
    mode_v_i = 1'b0;
  endtask

  initial begin
    int n;
    repeat (LAT) begin
      srcx_q.push_back(11'd0);
      srcy_q.push_back(10'd0);
    end

    reset_i = 1'b1;
    run(2);
    check("rst_mode", mode_o, 0);
    check("rst_ready", mode_ready_o, 1);
    check("rst_hs", hs_o, 0);
    reset_i = 1'b0;

    // Two frames of mode 0 after the pipeline has filled.
    run(10);
    clear_counts();
    n_fs = 0;
    run(240);
    check("m0_active", n_act, 64);
    check("m0_hs_active", n_hs, 32);
    check("m0_vs_active", n_vs, 30);
    check("m0_frames", n_fs, 2);
    wait_fs();
    wait_fs();
    check("m0_period", fs_period, 120);

    // Mid-frame switch to mode 1.
    run(20);
    request(2'd1);
    check("m1_ready_low", mode_ready_o, 0);
    check("m1_mode_held", mode_o, 0);
    n = 0;
    while (mode_o !== 2'd1 && n < 300) begin
      tick();
      n++;
    end
    check("m1_switched", mode_o, 1);
    wait_fs();
    wait_fs();
    check("m1_period", fs_period, 96);
    clear_counts();
    run(96);
    check("m1_active", n_act, 18);
    check("m1_hs_high", n_hs, 72);

    // Out-of-range index: no effect on mode or frame length.
    request(2'd3);
    wait_fs();
    wait_fs();
    wait_fs();
    check("inv_mode", mode_o, 1);
    check("inv_period", fs_period, 96);

    // Request landing on the frame-end cycle waits one more frame.
    n = 0;
    while (!(bm_h == 11 && bm_v == 7) && n < 200) begin
      tick();
      n++;
    end
    check("fe_reached", bm_h * 100 + bm_v, 1107);
    request(2'd0);
    check("fe_mode_kept", mode_o, 1);
    wait_fs();
    check("fe_next_frame", mode_o, 1);
    wait_fs();
    check("fe_applied", mode_o, 0);

    // Mode 2 frame length.
    request(2'd2);
    wait_fs();
    wait_fs();
    wait_fs();
    check("m2_period", fs_period, 35);
    check("m2_mode", mode_o, 2);

    // Reset with a request pending.
    run(7);
    request(2'd1);
    check("pend_ready_low", mode_ready_o, 0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("rst2_mode", mode_o, 0);
    check("rst2_ready", mode_ready_o, 1);
    check("rst2_sync", {hs_o, vs_o}, 0);
    check("rst2_r", r_o, 0);
    run(150);
    check("rst2_mode_kept", mode_o, 0);

`ifdef VGA_TEST_PATTERN_EN
    tp             = 1'b1;
    test_pattern_i = 1'b1;
    reset_i        = 1'b1;
    tick();
    reset_i = 1'b0;
    run(130);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
